// File: rtl/traffic_pkg.sv
// Shared lamp encodings, monitor state encoding and fault causes for the
// traffic signal monitor, its lamp-head checkers and the bench.
package traffic_pkg;

    localparam logic [1:0] DARK   = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;
    localparam logic [1:0] RED    = 2'b11;

    typedef enum logic [1:0] {
        ST_ARMING  = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } mon_state_t;

    typedef enum logic [2:0] {
        FC_NONE          = 3'd0,
        FC_CONFLICT      = 3'd1,
        FC_INVALID       = 3'd2,
        FC_ILLEGAL_TRANS = 3'd3,
        FC_SHORT_YELLOW  = 3'd4,
        FC_STUCK_GREEN   = 3'd5
    } fault_code_t;

    // Holding a code is legal; the only legal changes are green->yellow->red->green.
    function automatic logic trans_legal(input logic [1:0] prev, input logic [1:0] cur);
        logic ok;
        ok = 1'b0;
        if (prev == cur) begin
            ok = 1'b1;
        end else begin
            case ({prev, cur})
                {GREEN, YELLOW}: ok = 1'b1;
                {YELLOW, RED}:   ok = 1'b1;
                {RED, GREEN}:    ok = 1'b1;
                default:         ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/lamp_head_checker.sv
// Tracks one lamp head: previous code, dwell count, transition legality and
// the short-yellow condition on a yellow->red change.
module lamp_head_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW_CLKS = 8,
    parameter int DWELL_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic               update,
    input  logic [1:0]         lamp,
    output logic               trans_ok,
    output logic               short_yellow,
    output logic [DWELL_W-1:0] dwell
);

    logic [1:0]         prev_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               changed_s;

    // dwell is the count including the current sample; dwell_r excludes it
    always_comb begin
        changed_s    = (lamp != prev_r);
        trans_ok     = trans_legal(prev_r, lamp);
        short_yellow = (prev_r == YELLOW) && (lamp == RED) &&
                       (dwell_r < DWELL_W'(MIN_YELLOW_CLKS));
        if (changed_s) begin
            dwell = DWELL_W'(1);
        end else if (&dwell_r) begin
            dwell = dwell_r;
        end else begin
            dwell = dwell_r + DWELL_W'(1);
        end
    end

    // Previous-code and dwell registers; frozen unless arming or monitoring
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r  <= RED;
            dwell_r <= '0;
        end else if (capture) begin
            prev_r  <= lamp;
            dwell_r <= '0;
        end else if (update) begin
            prev_r  <= lamp;
            dwell_r <= dwell;
        end else begin
            prev_r  <= prev_r;
            dwell_r <= dwell_r;
        end
    end

endmodule

// File: rtl/traffic_signal_monitor.sv
// Watchdog on the controller's lamp outputs: arms on a legal pair, checks the
// intersection protocol each clock and latches the first fault until cleared.
module traffic_signal_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW_CLKS     = 8,
    parameter int MAX_FARM_GREEN_CLKS = 64,
    parameter int DWELL_W             = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] highway_signal,
    input  logic [1:0] farm_signal,
    input  logic       fault_clr,
    output logic       armed,
    output logic       fault,
    output logic       flash_req,
    output logic [2:0] fault_code,
    output logic [4:0] fault_vec
);

    mon_state_t         state_r, state_next_s;
    fault_code_t        code_next_s;
    logic [4:0]         vec_next_s;
    logic [4:0]         cause_s;
    logic               capture_s, update_s, legal_pair_s;
    logic               hw_ok_s, fm_ok_s, hw_sy_s, fm_sy_s;
    logic [DWELL_W-1:0] fm_dwell_s;
    logic [DWELL_W-1:0] hw_dwell_unused;

    assign capture_s = (state_r == ST_ARMING);
    assign update_s  = (state_r == ST_MONITOR);

    lamp_head_checker #(.MIN_YELLOW_CLKS(MIN_YELLOW_CLKS), .DWELL_W(DWELL_W)) u_hw (
        .clk(clk), .rst(rst), .capture(capture_s), .update(update_s),
        .lamp(highway_signal), .trans_ok(hw_ok_s), .short_yellow(hw_sy_s),
        .dwell(hw_dwell_unused)
    );

    lamp_head_checker #(.MIN_YELLOW_CLKS(MIN_YELLOW_CLKS), .DWELL_W(DWELL_W)) u_fm (
        .clk(clk), .rst(rst), .capture(capture_s), .update(update_s),
        .lamp(farm_signal), .trans_ok(fm_ok_s), .short_yellow(fm_sy_s),
        .dwell(fm_dwell_s)
    );

    // Cause detection, next state and next latched fault record
    always_comb begin
        legal_pair_s = ((highway_signal == RED) && (farm_signal != DARK)) ||
                       ((farm_signal == RED) && (highway_signal != DARK));
        cause_s[0] = (highway_signal != RED) && (farm_signal != RED);
        cause_s[1] = (highway_signal == DARK) || (farm_signal == DARK);
        cause_s[2] = !hw_ok_s || !fm_ok_s;
        cause_s[3] = hw_sy_s || fm_sy_s;
        cause_s[4] = (farm_signal == GREEN) &&
                     (fm_dwell_s >= DWELL_W'(MAX_FARM_GREEN_CLKS));

        state_next_s = state_r;
        code_next_s  = fault_code_t'(fault_code);
        vec_next_s   = fault_vec;
        case (state_r)
            ST_ARMING: begin
                if (legal_pair_s) begin
                    state_next_s = ST_MONITOR;
                end else begin
                    state_next_s = ST_ARMING;
                end
            end
            ST_MONITOR: begin
                if (|cause_s) begin
                    state_next_s = ST_FAULT;
                    vec_next_s   = cause_s;
                    if (cause_s[0]) begin
                        code_next_s = FC_CONFLICT;
                    end else if (cause_s[1]) begin
                        code_next_s = FC_INVALID;
                    end else if (cause_s[2]) begin
                        code_next_s = FC_ILLEGAL_TRANS;
                    end else if (cause_s[3]) begin
                        code_next_s = FC_SHORT_YELLOW;
                    end else begin
                        code_next_s = FC_STUCK_GREEN;
                    end
                end else begin
                    state_next_s = ST_MONITOR;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_next_s = ST_ARMING;
                    code_next_s  = FC_NONE;
                    vec_next_s   = 5'b00000;
                end else begin
                    state_next_s = ST_FAULT;
                end
            end
            default: begin
                state_next_s = ST_ARMING;
                code_next_s  = FC_NONE;
                vec_next_s   = 5'b00000;
            end
        endcase
    end

    // State and registered outputs, all decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_ARMING;
            armed      <= 1'b0;
            fault      <= 1'b0;
            flash_req  <= 1'b0;
            fault_code <= 3'd0;
            fault_vec  <= 5'b00000;
        end else begin
            state_r    <= state_next_s;
            armed      <= (state_next_s == ST_MONITOR);
            fault      <= (state_next_s == ST_FAULT);
            flash_req  <= (state_next_s == ST_FAULT);
            fault_code <= code_next_s;
            fault_vec  <= vec_next_s;
        end
    end

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Directed bench for traffic_signal_monitor with hand-computed expectations.
module tb_traffic_signal_monitor;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] highway_signal = RED;
    logic [1:0] farm_signal = RED;
    logic       fault_clr = 1'b0;
    logic       armed, fault, flash_req;
    logic [2:0] fault_code;
    logic [4:0] fault_vec;

    int tests = 0;
    int fails = 0;
    logic seen_s;

    traffic_signal_monitor #(
        .MIN_YELLOW_CLKS(8), .MAX_FARM_GREEN_CLKS(64), .DWELL_W(16)
    ) dut (
        .clk(clk), .rst(rst), .highway_signal(highway_signal),
        .farm_signal(farm_signal), .fault_clr(fault_clr), .armed(armed),
        .fault(fault), .flash_req(flash_req), .fault_code(fault_code),
        .fault_vec(fault_vec)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {armed, fault, flash_req, fault_code, fault_vec}
    task automatic check_all(input string tag, input logic a, input logic f,
                             input logic fr, input logic [2:0] c, input logic [4:0] v);
        check(tag, {5'd0, armed, fault, flash_req, fault_code, fault_vec},
                   {5'd0, a, f, fr, c, v});
    endtask

    // Hold inputs for n clocks, noting whether fault ever rose
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (fault !== 1'b0) seen_s = 1'b1;
        end
    endtask

    task automatic set(input logic [1:0] hw, input logic [1:0] fm);
        highway_signal = hw;
        farm_signal = fm;
    endtask

    task automatic clear_and_rearm(input logic [1:0] hw, input logic [1:0] fm);
        set(hw, fm);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check_all("clr_outputs", 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000);
        tick();
        check("rearm", {15'd0, armed}, 16'd1);
    endtask

    initial begin
        tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000);

        rst = 1'b0;
        set(GREEN, RED);
        tick();
        check("arm_first_edge", {15'd0, armed}, 16'd1);
        seen_s = 1'b0;
        run(200);
        check("hold_200_nofault", {15'd0, seen_s}, 16'd0);

        seen_s = 1'b0;
        set(YELLOW, RED); run(12);
        set(RED, RED);    run(2);
        set(RED, GREEN);  run(40);
        set(RED, YELLOW); run(12);
        set(RED, RED);    run(2);
        set(GREEN, RED);  run(5);
        check("legal_cycle_nofault", {15'd0, seen_s}, 16'd0);
        check("legal_cycle_armed", {15'd0, armed}, 16'd1);

        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check_all("clr_in_monitor", 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000);

        set(GREEN, GREEN);
        tick();
        check_all("conflict", 1'b0, 1'b1, 1'b1, 3'd1, 5'b00001);
        set(GREEN, RED);
        seen_s = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (flash_req !== 1'b1) seen_s = 1'b1;
        end
        check("flash_held_100", {15'd0, seen_s}, 16'd0);
        check("code_frozen", {13'd0, fault_code}, 16'd1);

        clear_and_rearm(GREEN, RED);

        seen_s = 1'b0;
        set(YELLOW, RED); run(5);
        check("yellow5_nofault", {15'd0, seen_s}, 16'd0);
        set(RED, RED);
        tick();
        check_all("short_yellow", 1'b0, 1'b1, 1'b1, 3'd4, 5'b01000);

        clear_and_rearm(GREEN, RED);
        set(RED, RED);
        tick();
        check_all("illegal_trans", 1'b0, 1'b1, 1'b1, 3'd3, 5'b00100);

        clear_and_rearm(GREEN, RED);
        set(DARK, RED);
        tick();
        check_all("invalid", 1'b0, 1'b1, 1'b1, 3'd2, 5'b00110);

        clear_and_rearm(GREEN, RED);
        seen_s = 1'b0;
        set(YELLOW, RED); run(8);
        set(RED, RED);    run(1);
        set(RED, GREEN);  run(63);
        check("green63_nofault", {15'd0, seen_s}, 16'd0);
        tick();
        check_all("stuck_green_64", 1'b0, 1'b1, 1'b1, 3'd5, 5'b10000);

        clear_and_rearm(RED, RED);
        seen_s = 1'b0;
        set(RED, GREEN);  run(63);
        set(RED, YELLOW); run(8);
        set(RED, RED);    run(1);
        set(GREEN, RED);  run(1);
        check("green63_then_yellow", {15'd0, seen_s}, 16'd0);

        set(GREEN, YELLOW);
        tick();
        check_all("multi_cause", 1'b0, 1'b1, 1'b1, 3'd1, 5'b00101);

        rst = 1'b1;
        tick();
        check_all("reset_mid_fault", 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000);
        rst = 1'b0;
        set(GREEN, RED);
        tick();
        check("arm_after_reset", {15'd0, armed}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
